// File: rtl/k2red_pkg.sv
// k2red_pkg: definitions shared by the K2RED multiplier front end and the
// shift reducer.
//   - k2red_state_e : multiplier FSM states (IDLE / BUSY / DONE)
//   - K2RED_LOG_Q   : default operand / modulus width
//   - K2RED_LOG_L   : default width of the l1/l2/l3 shift amounts
//   - k2red_ndig()  : number of DW-bit digits in a LOG_Q-bit operand
package k2red_pkg;

    localparam int K2RED_LOG_Q = 32;
    localparam int K2RED_LOG_L = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } k2red_state_e;

    function automatic int k2red_ndig(input int log_q, input int dw);
        return log_q / dw;
    endfunction

endpackage

// File: rtl/k2red_digit_mac.sv
// k2red_digit_mac: one digit-serial multiply-accumulate step (combinational).
//   acc_out = acc_in + ((x * digit) << (DW * idx))
// Ports:
//   acc_in  [2*LOG_Q]  running accumulator
//   x       [LOG_Q]    multiplicand
//   digit   [DW]       current multiplier digit
//   idx     [CW]       digit index (selects the weight of the partial product)
//   acc_out [2*LOG_Q]  updated accumulator
module k2red_digit_mac
    import k2red_pkg::*;
#(
    parameter int LOG_Q = K2RED_LOG_Q,
    parameter int DW    = 8,
    parameter int CW    = 2
) (
    input  logic [2*LOG_Q-1:0] acc_in,
    input  logic [LOG_Q-1:0]   x,
    input  logic [DW-1:0]      digit,
    input  logic [CW-1:0]      idx,
    output logic [2*LOG_Q-1:0] acc_out
);

    localparam int AW = 2 * LOG_Q;
    localparam int PW = LOG_Q + DW;
    localparam int SW = $clog2(AW);

    logic [PW-1:0] pp;
    logic [AW-1:0] pp_ext;
    logic [SW-1:0] sh;

    always_comb begin
        pp      = PW'(x) * PW'(digit);
        pp_ext  = AW'(pp);
        sh      = SW'(idx) * SW'(DW);
        // Largest shift is DW*(NDIG-1), so the shifted product never leaves AW bits.
        acc_out = acc_in + (pp_ext << sh);
    end

endmodule

// File: rtl/k2red_mul_iter.sv
// k2red_mul_iter: iterative digit-serial LOG_Q x LOG_Q unsigned multiplier
// feeding the K2RED shift reducer. One DW-bit digit of Y is consumed per
// cycle (LSB digit first); the 2*LOG_Q-bit product appears on A with a
// one-cycle valid_out pulse, together with the captured Q/l1/l2/l3 sideband.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   X, Y                   operands (LOG_Q bits)
//   Q_in, l1_in..l3_in     sideband, carried alongside the product
//   valid_in / ready_out   operation handshake (accepted when both high)
//   A                      product X*Y (2*LOG_Q bits)
//   Q, l1, l2, l3          sideband aligned with A
//   valid_out              one-cycle pulse marking A / sideband valid
// Build option: K2RED_MUL_OUT_REG_EN adds one output register stage after
// DONE (latency NDIG+2 instead of NDIG+1, throughput unchanged).
module k2red_mul_iter
    import k2red_pkg::*;
#(
    parameter int LOG_Q = K2RED_LOG_Q,
    parameter int LOG_L = K2RED_LOG_L,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LOG_Q-1:0]     X,
    input  logic [LOG_Q-1:0]     Y,
    input  logic [LOG_Q-1:0]     Q_in,
    input  logic [LOG_L-1:0]     l1_in,
    input  logic [LOG_L-1:0]     l2_in,
    input  logic [LOG_L-1:0]     l3_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [2*LOG_Q-1:0]   A,
    output logic [LOG_Q-1:0]     Q,
    output logic [LOG_L-1:0]     l1,
    output logic [LOG_L-1:0]     l2,
    output logic [LOG_L-1:0]     l3,
    output logic                 valid_out
);

    localparam int NDIG = k2red_ndig(LOG_Q, DW);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * LOG_Q;

    generate
        if ((LOG_Q % DW) != 0) begin : g_bad_dw
            $error("k2red_mul_iter: LOG_Q must be a multiple of DW");
        end
    endgenerate

    k2red_state_e state_q, state_d;
    logic [LOG_Q-1:0] x_q, x_d;
    logic [LOG_Q-1:0] y_q, y_d;       // shifts right one digit per BUSY cycle
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    // Sideband of the operation in flight.
    logic [LOG_Q-1:0] sq_q, sq_d;
    logic [LOG_L-1:0] sl1_q, sl1_d, sl2_q, sl2_d, sl3_q, sl3_d;
    // Result registers: loaded on the last BUSY cycle, held until the next DONE,
    // so a new accept in DONE can overwrite the in-flight copies safely.
    logic [AW-1:0]    a_q, a_d;
    logic [LOG_Q-1:0] q_q, q_d;
    logic [LOG_L-1:0] l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;

    logic [AW-1:0]    mac_out;
    logic             done;

    k2red_digit_mac #(.LOG_Q(LOG_Q), .DW(DW), .CW(CW)) u_mac (
        .acc_in  (acc_q),
        .x       (x_q),
        .digit   (y_q[DW-1:0]),
        .idx     (cnt_q),
        .acc_out (mac_out)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sq_d      = sq_q;
        sl1_d     = sl1_q;
        sl2_d     = sl2_q;
        sl3_d     = sl3_q;
        a_d       = a_q;
        q_d       = q_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        l3_d      = l3_q;
        ready_out = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_out = 1'b1;
            end
            ST_BUSY: begin
                acc_d = mac_out;
                y_d   = y_q >> DW;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    a_d     = mac_out;
                    q_d     = sq_q;
                    l1_d    = sl1_q;
                    l2_d    = sl2_q;
                    l3_d    = sl3_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_out = 1'b1;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept is common to IDLE and DONE (ready_out only high there).
        if (ready_out && valid_in) begin
            x_d     = X;
            y_d     = Y;
            sq_d    = Q_in;
            sl1_d   = l1_in;
            sl2_d   = l2_in;
            sl3_d   = l3_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            sl1_q   <= '0;
            sl2_q   <= '0;
            sl3_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            l3_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            sl1_q   <= sl1_d;
            sl2_q   <= sl2_d;
            sl3_q   <= sl3_d;
            a_q     <= a_d;
            q_q     <= q_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            l3_q    <= l3_d;
        end
    end

`ifdef K2RED_MUL_OUT_REG_EN
    logic             vo_q, vo_d;
    logic [AW-1:0]    ao_q, ao_d;
    logic [LOG_Q-1:0] qo_q, qo_d;
    logic [LOG_L-1:0] l1o_q, l1o_d, l2o_q, l2o_d, l3o_q, l3o_d;

    always_comb begin
        vo_d  = done;
        ao_d  = ao_q;
        qo_d  = qo_q;
        l1o_d = l1o_q;
        l2o_d = l2o_q;
        l3o_d = l3o_q;
        if (done) begin
            ao_d  = a_q;
            qo_d  = q_q;
            l1o_d = l1_q;
            l2o_d = l2_q;
            l3o_d = l3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vo_q  <= 1'b0;
            ao_q  <= '0;
            qo_q  <= '0;
            l1o_q <= '0;
            l2o_q <= '0;
            l3o_q <= '0;
        end else begin
            vo_q  <= vo_d;
            ao_q  <= ao_d;
            qo_q  <= qo_d;
            l1o_q <= l1o_d;
            l2o_q <= l2o_d;
            l3o_q <= l3o_d;
        end
    end

    assign valid_out = vo_q;
    assign A         = ao_q;
    assign Q         = qo_q;
    assign l1        = l1o_q;
    assign l2        = l2o_q;
    assign l3        = l3o_q;
`else
    assign valid_out = done;
    assign A         = a_q;
    assign Q         = q_q;
    assign l1        = l1_q;
    assign l2        = l2_q;
    assign l3        = l3_q;
`endif

endmodule

// File: tb/tb_k2red_mul_iter.sv
module tb_k2red_mul_iter;

    localparam int LQ   = 32;
    localparam int LL   = 4;
    localparam int DW   = 8;
    localparam int NDIG = LQ / DW;
`ifdef K2RED_MUL_OUT_REG_EN
    localparam int LAT  = NDIG + 1;   // edges from accept edge to valid_out cycle
`else
    localparam int LAT  = NDIG;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [LQ-1:0]   X = '0, Y = '0, Q_in = '0;
    logic [LL-1:0]   l1_in = '0, l2_in = '0, l3_in = '0;
    logic            valid_in = 1'b0;
    logic            ready_out, valid_out;
    logic [2*LQ-1:0] A;
    logic [LQ-1:0]   Q;
    logic [LL-1:0]   l1, l2, l3;

    k2red_mul_iter #(.LOG_Q(LQ), .LOG_L(LL), .DW(DW)) dut (
        .clk(clk), .rst(rst), .X(X), .Y(Y), .Q_in(Q_in),
        .l1_in(l1_in), .l2_in(l2_in), .l3_in(l3_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .A(A), .Q(Q), .l1(l1), .l2(l2), .l3(l3), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*LQ-1:0] a;
        logic [LQ-1:0]   q;
        logic [LL-1:0]   l1, l2, l3;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid_out cycle must match the oldest expected result,
    // including the exact cycle it was due.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid_out", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("A", A, e.a);
                chk("Q", 64'(Q), 64'(e.q));
                chk("l1", 64'(l1), 64'(e.l1));
                chk("l2", 64'(l2), 64'(e.l2));
                chk("l3", 64'(l3), 64'(e.l3));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; waits for ready, presents the op for one edge and
    // returns at the following negedge with valid_in low.
    task automatic issue(input logic [LQ-1:0] x, input logic [LQ-1:0] y,
                         input logic [LQ-1:0] q, input logic [LL-1:0] a1,
                         input logic [LL-1:0] a2, input logic [LL-1:0] a3,
                         input bit expect_result);
        int n = 0;
        exp_t e;
        while (!ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) begin
            chk("ready_timeout", 64'(ready_out), 64'd1);
        end else begin
            X = x; Y = y; Q_in = q; l1_in = a1; l2_in = a2; l3_in = a3;
            valid_in = 1'b1;
            if (expect_result) begin
                e.a = 64'(x) * 64'(y);
                e.q = q; e.l1 = a1; e.l2 = a2; e.l3 = a3;
                e.cyc = cyc + 1 + LAT;
                sb.push_back(e);
            end
            @(negedge clk);
            valid_in = 1'b0;
            chk("ready_low_after_accept", 64'(ready_out), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_ready", 64'(ready_out), 64'd1);
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_A", A, 64'd0);
        chk("rst_Q", 64'(Q), 64'd0);
        rst = 1'b0;
        idle(1);

        // Directed cases
        issue(32'd123456789, 32'd987654321, 32'd7, 4'd1, 4'd2, 4'd3, 1'b1);
        // ready stays low for the rest of the BUSY cycles
        for (int i = 1; i < NDIG; i++) begin
            chk("ready_low_busy", 64'(ready_out), 64'd0);
            idle(1);
        end
        idle(3);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2148794369, 4'd2, 4'd1, 4'd3, 1'b1);
        idle(8);
        issue(32'd0, 32'hDEAD_BEEF, 32'd11, 4'd0, 4'd0, 4'd0, 1'b1);
        idle(8);

        // Back-to-back: second op accepted in the DONE cycle
        issue(32'h1234_5678, 32'h9ABC_DEF0, 32'd1, 4'd4, 4'd5, 4'd6, 1'b1);
        issue(32'hCAFE_F00D, 32'h0000_0001, 32'd2, 4'd7, 4'd8, 4'd9, 1'b1);
        issue(32'h8000_0000, 32'h8000_0000, 32'd3, 4'd15, 4'd14, 4'd13, 1'b1);
        idle(8);

        // valid_in during BUSY with other operands must be ignored
        issue(32'd1000, 32'd2000, 32'd5, 4'd1, 4'd1, 4'd1, 1'b1);
        X = 32'hFFFF_0000; Y = 32'h0000_FFFF; Q_in = 32'd99;
        valid_in = 1'b1;
        idle(2);
        valid_in = 1'b0;
        idle(8);

        // Reset mid-BUSY aborts the operation
        issue(32'd77, 32'd88, 32'd6, 4'd3, 4'd3, 4'd3, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("abort_ready", 64'(ready_out), 64'd1);
        chk("abort_valid", 64'(valid_out), 64'd0);
        chk("abort_A_cleared", A, 64'd0);
        idle(8);
        issue(32'd31337, 32'd4242, 32'd8, 4'd2, 4'd4, 4'd8, 1'b1);
        idle(8);

        // Random operations, random gaps (zero gap means back-to-back)
        for (int i = 0; i < 40; i++) begin
            logic [LQ-1:0] rx, ry;
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) rx = '0;
            if ($urandom_range(0, 7) == 0) ry = '1;
            issue(rx, ry, $urandom, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
            idle($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 6));
        end

        // Drain
        for (int n = 0; n < 200 && sb.size() != 0; n++) idle(1);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
